// File: rtl/boot_seq_if.sv
// CSR bus between a host (master) and the boot sequencer (slave).
// The read data path is combinational from the address.
interface boot_seq_if;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;

    modport master (output csr_a, output csr_di, output csr_we, input  csr_do);
    modport slave  (input  csr_a, input  csr_di, input  csr_we, output csr_do);
endinterface

// File: rtl/boot_seq.sv
// SoC boot sequencer: waits for the configuration word, holds porst_n low,
// releases the SoC and supports a CSR-triggered soft restart with recovery forcing.
module boot_seq #(
    parameter logic [4:0]  BASE_ADDR   = 5'h0,
    parameter int          DEB_CYCLES  = 16,
    parameter logic [15:0] HOLD_CYCLES = 16'd1000,
    parameter logic [7:0]  CFG_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    boot_seq_if.slave   bus,
    input  logic        cfg_done,
    input  logic [15:0] cfg,
    input  logic        recovery_btn_n,
    output logic        cfg_start,
    output logic        force_recovery,
    output logic        porst_n,
    output logic [3:0]  boot_src
);

    typedef enum logic [1:0] {
        WAIT_CFG = 2'b00,
        HOLD     = 2'b01,
        RUN      = 2'b10,
        RESTART  = 2'b11
    } state_t;

    localparam int          DEB_W     = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = HOLD_CYCLES - 16'd1;
    localparam logic [7:0]  TO_LAST   = CFG_TIMEOUT - 8'd1;
    localparam logic [4:0]  CTRL_ADDR = BASE_ADDR + 5'd1;

    state_t             state_r;
    state_t             state_s;
    logic [7:0]         wait_cnt_r;
    logic [15:0]        hold_cnt_r;
    logic [1:0]         sync_r;
    logic               btn_r;
    logic [DEB_W-1:0]   deb_cnt_r;
    logic               sw_recovery_r;
    logic               cfg_blank_r;
    logic               cfg_timeout_r;
    logic               ctrl_wr_s;
    logic               cfg_accept_s;
    logic               timeout_s;

    assign ctrl_wr_s    = bus.csr_we && (bus.csr_a == CTRL_ADDR);
    // The first WAIT_CFG cycle (counter still zero) never accepts cfg_done.
    assign cfg_accept_s = (state_r == WAIT_CFG) && cfg_done && (wait_cnt_r != 8'd0);
    assign timeout_s    = (state_r == WAIT_CFG) && (wait_cnt_r == TO_LAST) && !cfg_accept_s;

    // Button synchronizer and debouncer; btn_r is active-low like the raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r    <= 2'b11;
            btn_r     <= 1'b1;
            deb_cnt_r <= '0;
        end else begin
            sync_r <= {sync_r[0], recovery_btn_n};
            if (sync_r[1] == btn_r) begin
                deb_cnt_r <= '0;
            end else if (deb_cnt_r == DEB_LAST) begin
                btn_r     <= sync_r[1];
                deb_cnt_r <= '0;
            end else begin
                deb_cnt_r <= deb_cnt_r + {{(DEB_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            WAIT_CFG: begin
                if (cfg_accept_s || timeout_s) begin
                    state_s = HOLD;
                end else begin
                    state_s = WAIT_CFG;
                end
            end
            HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_s = RUN;
                end else begin
                    state_s = HOLD;
                end
            end
            RUN: begin
                if (ctrl_wr_s && bus.csr_di[0]) begin
                    state_s = RESTART;
                end else begin
                    state_s = RUN;
                end
            end
            RESTART: state_s = WAIT_CFG;
            default: state_s = WAIT_CFG;
        endcase
    end

    // State register and per-state cycle counters (cleared outside their state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= WAIT_CFG;
            wait_cnt_r <= 8'd0;
            hold_cnt_r <= 16'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= (state_r == WAIT_CFG) ? (wait_cnt_r + 8'd1) : 8'd0;
            hold_cnt_r <= (state_r == HOLD) ? (hold_cnt_r + 16'd1) : 16'd0;
        end
    end

    // Registered outputs; porst_n and cfg_start follow the next state so they
    // change on the same edge as the transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            porst_n        <= 1'b0;
            cfg_start      <= 1'b0;
            force_recovery <= 1'b0;
            boot_src       <= 4'hf;
            cfg_blank_r    <= 1'b0;
            cfg_timeout_r  <= 1'b0;
        end else begin
            porst_n   <= (state_s == RUN);
            cfg_start <= (state_s == RESTART);
            if (state_r == WAIT_CFG) begin
                force_recovery <= ~btn_r | sw_recovery_r;
            end
            if (cfg_accept_s) begin
                boot_src    <= (cfg == 16'hffff) ? 4'hf : cfg[3:0];
                cfg_blank_r <= (cfg == 16'hffff);
            end else if (timeout_s) begin
                boot_src      <= 4'hf;
                cfg_timeout_r <= 1'b1;
            end else if (state_r == RESTART) begin
                cfg_blank_r   <= 1'b0;
                cfg_timeout_r <= 1'b0;
            end
        end
    end

    // Sticky software recovery request, writable in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_recovery_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            sw_recovery_r <= bus.csr_di[1];
        end
    end

    // CSR read mux.
    always_comb begin
        bus.csr_do = 8'h00;
        if (bus.csr_a == BASE_ADDR) begin
            bus.csr_do = {state_r, cfg_timeout_r, cfg_blank_r, boot_src};
        end else if (bus.csr_a == CTRL_ADDR) begin
            bus.csr_do = {6'b000000, sw_recovery_r, 1'b0};
        end else begin
            bus.csr_do = 8'h00;
        end
    end

endmodule

// File: tb/tb_boot_seq.sv
// Directed self-checking bench for boot_seq with default parameters.
module tb_boot_seq;

    logic        clk;
    logic        rst_n;
    logic        cfg_done;
    logic [15:0] cfg;
    logic        recovery_btn_n;
    logic        cfg_start;
    logic        force_recovery;
    logic        porst_n;
    logic [3:0]  boot_src;
    int          checks;
    int          errors;
    logic [7:0]  rdata;

    boot_seq_if bus ();

    boot_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .cfg_done       (cfg_done),
        .cfg            (cfg),
        .recovery_btn_n (recovery_btn_n),
        .cfg_start      (cfg_start),
        .force_recovery (force_recovery),
        .porst_n        (porst_n),
        .boot_src       (boot_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] addr, output logic [7:0] d);
        bus.csr_a = addr;
        #1;
        d = bus.csr_do;
    endtask

    task automatic chk_status(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        rd(5'h00, d);
        chk(tag, {8'h00, d}, {8'h00, exp});
    endtask

    task automatic wr_ctrl(input logic [7:0] data);
        bus.csr_a  = 5'h01;
        bus.csr_di = data;
        bus.csr_we = 1'b1;
        step(1);
        bus.csr_we = 1'b0;
        bus.csr_di = 8'h00;
        bus.csr_a  = 5'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        cfg_done = 1'b0;
        cfg = 16'h0000;
        recovery_btn_n = 1'b1;
        bus.csr_a = 5'h00;
        bus.csr_di = 8'h00;
        bus.csr_we = 1'b0;

        // Reset values
        step(2);
        chk("rst_porst", {15'h0, porst_n}, 16'h0000);
        chk("rst_boot_src", {12'h0, boot_src}, 16'h000f);
        chk("rst_force", {15'h0, force_recovery}, 16'h0000);
        chk("rst_cfg_start", {15'h0, cfg_start}, 16'h0000);
        chk_status("rst_status", 8'h0f);
        rd(5'h01, rdata);
        chk("rst_ctrl", {8'h00, rdata}, 16'h0000);
        rd(5'h07, rdata);
        chk("other_addr", {8'h00, rdata}, 16'h0000);
        rst_n = 1'b1;

        // Normal boot with a sub-threshold button glitch in WAIT_CFG
        step(2);
        recovery_btn_n = 1'b0;
        step(15);
        recovery_btn_n = 1'b1;
        step(12);
        cfg_done = 1'b1;
        cfg = 16'h1235;
        step(1);
        cfg_done = 1'b0;
        chk_status("boot_hold_status", 8'h45);
        chk("boot_src_5", {12'h0, boot_src}, 16'h0005);
        chk("glitch_force", {15'h0, force_recovery}, 16'h0000);
        wr_ctrl(8'h01);
        step(998);
        chk("hold_porst_last", {15'h0, porst_n}, 16'h0000);
        chk_status("hold_last_status", 8'h45);
        step(1);
        chk("run_porst", {15'h0, porst_n}, 16'h0001);
        chk_status("run_status", 8'h85);
        rd(5'h01, rdata);
        chk("ctrl_after_hold_wr", {8'h00, rdata}, 16'h0000);

        // Soft reset with sw_recovery
        wr_ctrl(8'h03);
        chk("sr_porst", {15'h0, porst_n}, 16'h0000);
        chk("sr_cfg_start", {15'h0, cfg_start}, 16'h0001);
        chk_status("sr_status", 8'hc5);
        rd(5'h01, rdata);
        chk("sr_ctrl", {8'h00, rdata}, 16'h0002);
        step(1);
        chk("sr_cfg_start_end", {15'h0, cfg_start}, 16'h0000);
        step(1);
        chk("sr_force", {15'h0, force_recovery}, 16'h0001);
        chk_status("sr_wait_status", 8'h05);

        // Clear sw_recovery, then force via held button with blank config
        wr_ctrl(8'h00);
        step(1);
        chk("sw_clear_force", {15'h0, force_recovery}, 16'h0000);
        recovery_btn_n = 1'b0;
        step(25);
        chk("btn_force", {15'h0, force_recovery}, 16'h0001);
        cfg_done = 1'b1;
        cfg = 16'hffff;
        step(1);
        cfg_done = 1'b0;
        recovery_btn_n = 1'b1;
        chk_status("blank_hold_status", 8'h5f);
        step(1000);
        chk_status("blank_run_status", 8'h9f);
        chk("blank_force_run", {15'h0, force_recovery}, 16'h0001);
        chk("blank_porst", {15'h0, porst_n}, 16'h0001);

        // Restart; cfg_done ignored in first WAIT_CFG cycle
        wr_ctrl(8'h01);
        cfg_done = 1'b1;
        cfg = 16'h00a7;
        step(1);
        step(1);
        chk_status("first_cycle_ignore", 8'h0f);
        step(1);
        cfg_done = 1'b0;
        chk_status("second_cycle_accept", 8'h47);
        chk("btn_released_force", {15'h0, force_recovery}, 16'h0000);

        // Async reset in the middle of HOLD
        step(100);
        rst_n = 1'b0;
        #1;
        chk("ar_porst", {15'h0, porst_n}, 16'h0000);
        chk("ar_boot_src", {12'h0, boot_src}, 16'h000f);
        chk_status("ar_status", 8'h0f);
        step(2);
        chk("ar_cfg_start", {15'h0, cfg_start}, 16'h0000);
        rst_n = 1'b1;
        step(1);
        chk("ar_cfg_start_after", {15'h0, cfg_start}, 16'h0000);
        chk_status("ar_wait_status", 8'h0f);

        // Timeout
        do_reset();
        step(254);
        chk_status("to_before", 8'h0f);
        step(1);
        chk_status("to_hold_status", 8'h6f);
        chk("to_porst", {15'h0, porst_n}, 16'h0000);

        // cfg_done wins over simultaneous timeout
        do_reset();
        step(254);
        cfg_done = 1'b1;
        cfg = 16'h0003;
        step(1);
        cfg_done = 1'b0;
        chk_status("prio_status", 8'h43);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
